btb_assoc: RTL and testbench

- Parametrised, set-associative branch target buffer for the fetch stage. It is the successor to the direct-mapped 4-entry predictor.
- Each entry holds a tag, a target and an n-bit saturating counter, with true-LRU replacement per set.
- Lookup is combinational on the fetch PC. Updates come from the resolve stage, one per cycle.
- Adds a global flush, and allocates only on taken branches.

---
 rtl/btb_assoc.sv | 86 ++++++++
 tb/tb_btb_assoc.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with saturating counters and true-LRU replacement
// Ports: CLK/nRST clock and async active-low reset; flush clears all valid bits;
//        rd_pc -> hit/pred_taken/pred_target combinational lookup;
//        upd_en/upd_pc/upd_taken/upd_target resolved-branch update, one per cycle.
module btb_assoc #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int CTR_W = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        flush,
  input  logic [31:0] rd_pc,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] MAX = '1;
  logic [WAYS-1:0] vld [SETS];
  logic [TAG_W-1:0] tag [SETS][WAYS];
  logic [31:0] tgt [SETS][WAYS];
  logic [CTR_W-1:0] ctr [SETS][WAYS];
  logic lru [SETS];
  logic [IDX_W-1:0] ri, ui;
  logic [TAG_W-1:0] rt, ut;
  logic [WAYS-1:0] rm, um;
  logic uw, uhit, way;
  logic [CTR_W-1:0] c, cn;
  assign ri = rd_pc[IDX_W+1:2];
  assign rt = rd_pc[31:IDX_W+2];
  assign ui = upd_pc[IDX_W+1:2];
  assign ut = upd_pc[31:IDX_W+2];
  always_comb begin
    hit = 1'b0;
    pred_taken = 1'b0;
    pred_target = '0;
    rm = '0;
    um = '0;
    uw = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      rm[w] = vld[ri][w] && tag[ri][w] == rt;
      um[w] = vld[ui][w] && tag[ui][w] == ut;
      if (rm[w]) begin
        hit = 1'b1;
        pred_taken = ctr[ri][w][CTR_W-1];
        pred_target = tgt[ri][w];
      end
      if (um[w]) uw = 1'(w);
    end
    uhit = |um;
    // hit way, else lowest invalid way, else the LRU way
    way = WAYS == 1 ? 1'b0 : uhit ? uw : !vld[ui][0] ? 1'b0 : !vld[ui][WAYS-1] ? 1'b1 : lru[ui];
    c = ctr[ui][way];
    cn = upd_taken ? (c == MAX ? c : c + 1'b1) : (c == '0 ? c : c - 1'b1);
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        vld[s] <= '0;
        lru[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          tag[s][w] <= '0;
          tgt[s][w] <= '0;
          ctr[s][w] <= WEAK;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) vld[s] <= '0;
    end else if (upd_en && (uhit || upd_taken)) begin
      ctr[ui][way] <= uhit ? cn : WEAK;
      if (upd_taken) tgt[ui][way] <= upd_target;
      tag[ui][way] <= ut;
      vld[ui][way] <= 1'b1;
      if (WAYS == 2) lru[ui] <= ~way;
    end
  end
  // a tag stored twice in one set would make the lookup ambiguous
  always @(posedge CLK) if (nRST) assert ($onehot0(rm) && $onehot0(um));
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: scoreboard bench for btb_assoc lookup, counters, LRU, flush and reset
module tb_btb_assoc;
  logic CLK = 0, nRST = 0, flush = 0, upd_en = 0, upd_taken = 0;
  logic [31:0] rd_pc = 0, upd_pc = 0, upd_target = 0;
  logic hit, pred_taken;
  logic [31:0] pred_target;
  int passed = 0, total = 0;
  logic [33:0] q[$];
  logic [33:0] got, e;

  always #5 CLK = ~CLK;

  btb_assoc dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .rd_pc(rd_pc), .hit(hit),
    .pred_taken(pred_taken), .pred_target(pred_target), .upd_en(upd_en),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  task automatic probe(input logic [31:0] pc, input logic [33:0] exp);
    q.push_back(exp);
    rd_pc = pc;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    @(negedge CLK);
    upd_en = 1; upd_pc = pc; upd_taken = tk; upd_target = tg;
    @(posedge CLK);
    #1 upd_en = 0;
  endtask

  task automatic test_reset;
    logic [31:0] pcs[3] = '{32'h40, 32'h0, 32'hFFFF_FFFC};
    @(negedge CLK);
    nRST = 0;
    for (int i = 0; i < 3; i++) begin
      probe(pcs[i], 34'h0);
      got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
      if (got !== e) $display("FAIL reset pc=%h got %h want %h", pcs[i], got, e); else passed++;
    end
    @(negedge CLK) nRST = 1;
  endtask

  task automatic test_alloc;
    logic [31:0] pcs[4] = '{32'h40, 32'h41, 32'h44, 32'h20};
    logic [33:0] ex[4] = '{{2'b11, 32'h100}, {2'b11, 32'h100}, 34'h0, 34'h0};
    upd(32'h40, 1, 32'h100);
    for (int i = 0; i < 4; i++) begin
      probe(pcs[i], ex[i]);
      got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
      if (got !== e) $display("FAIL alloc pc=%h got %h want %h", pcs[i], got, e); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    @(negedge CLK);
    upd_en = 1; upd_pc = 32'h44; upd_taken = 1; upd_target = 32'h200;
    probe(32'h44, 34'h0);
    got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
    if (got !== e) $display("FAIL bypass got %h want %h", got, e); else passed++;
    @(posedge CLK);
    #1 upd_en = 0;
    probe(32'h44, {2'b11, 32'h200});
    got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
    if (got !== e) $display("FAIL after_b2b got %h want %h", got, e); else passed++;
  endtask

  task automatic test_counter;
    logic tk[9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic pt[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic [31:0] tg;
    for (int i = 0; i < 9; i++) begin
      upd(32'h40, tk[i], i == 6 ? 32'h104 : 32'h100);
      tg = i >= 6 ? 32'h104 : 32'h100;
      probe(32'h40, {1'b1, pt[i], tg});
      got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
      if (got !== e) $display("FAIL counter step=%0d got %h want %h", i, got, e); else passed++;
    end
  endtask

  task automatic test_lru;
    logic [31:0] pcs[3] = '{32'h00, 32'h40, 32'h20};
    logic [33:0] ex[3] = '{{2'b11, 32'hA0}, {2'b11, 32'hC0}, 34'h0};
    @(negedge CLK);
    nRST = 0;
    probe(32'h40, 34'h0);
    got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
    if (got !== e) $display("FAIL async_reset got %h want %h", got, e); else passed++;
    @(negedge CLK) nRST = 1;
    upd(32'h00, 1, 32'hA0);
    upd(32'h20, 1, 32'hB0);
    upd(32'h00, 1, 32'hA0);
    upd(32'h40, 1, 32'hC0);
    for (int i = 0; i < 3; i++) begin
      probe(pcs[i], ex[i]);
      got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
      if (got !== e) $display("FAIL lru pc=%h got %h want %h", pcs[i], got, e); else passed++;
    end
  endtask

  task automatic test_nt_miss;
    logic [31:0] pcs[5] = '{32'h80, 32'h20, 32'h00, 32'h40, 32'h80};
    logic [33:0] ex[5] = '{34'h0, {2'b11, 32'hD0}, 34'h0, {2'b11, 32'hC0}, 34'h0};
    upd(32'h80, 0, 32'hE0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) upd(32'h20, 1, 32'hD0);
      probe(pcs[i], ex[i]);
      got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
      if (got !== e) $display("FAIL nt_miss pc=%h got %h want %h", pcs[i], got, e); else passed++;
    end
  endtask

  task automatic test_flush;
    logic [31:0] pcs[4] = '{32'h00, 32'h20, 32'h40, 32'h60};
    upd(32'h20, 1, 32'hD0);
    upd(32'h40, 1, 32'hC0);
    @(negedge CLK);
    flush = 1; upd_en = 1; upd_pc = 32'h60; upd_taken = 1; upd_target = 32'h160;
    probe(32'h40, {2'b11, 32'hC0});
    got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
    if (got !== e) $display("FAIL flush_cycle got %h want %h", got, e); else passed++;
    @(posedge CLK);
    #1 flush = 0; upd_en = 0;
    for (int i = 0; i < 4; i++) begin
      probe(pcs[i], 34'h0);
      got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
      if (got !== e) $display("FAIL flushed pc=%h got %h want %h", pcs[i], got, e); else passed++;
    end
    upd(32'h40, 1, 32'h140);
    probe(32'h40, {2'b11, 32'h140});
    got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
    if (got !== e) $display("FAIL realloc got %h want %h", got, e); else passed++;
    upd(32'h40, 0, 32'h0);
    probe(32'h40, {2'b10, 32'h140});
    got = {hit, pred_taken, pred_target}; e = q.pop_front(); total++;
    if (got !== e) $display("FAIL fresh_ctr got %h want %h", got, e); else passed++;
  endtask

  initial begin
    test_reset;
    test_alloc;
    test_back_to_back;
    test_counter;
    test_lru;
    test_nt_miss;
    test_flush;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
